// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop rx synchronizer, 16x oversampled start/mid-bit sampling,
// delivers each byte with a one-cycle rx_done pulse and a framing-error flag.
module uart_receiver #(
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  rx,
  input  logic                  tick,
  output logic [BYTE_WIDTH-1:0] data_out,
  output logic                  rx_done,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned OSC_W = $clog2(OVERSAMPLE);
  localparam int unsigned NB_W  = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam logic [OSC_W-1:0] OSC_HALF = OSC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OSC_W-1:0] OSC_LAST = OSC_W'(OVERSAMPLE - 1);
  localparam logic [NB_W-1:0]  NB_LAST  = NB_W'(BYTE_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_next;
  logic                  rx_meta, rx_s;
  logic                  armed, armed_next;
  logic [OSC_W-1:0]      osc, osc_next;
  logic [NB_W-1:0]       nbits, nbits_next;
  logic [BYTE_WIDTH-1:0] shreg, shreg_next;
  logic [BYTE_WIDTH-1:0] data_next;
  logic                  done_next, ferr_next, busy_next;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      armed     <= 1'b0;
      osc       <= '0;
      nbits     <= '0;
      shreg     <= '0;
      data_out  <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      state     <= state_next;
      armed     <= armed_next;
      osc       <= osc_next;
      nbits     <= nbits_next;
      shreg     <= shreg_next;
      data_out  <= data_next;
      rx_done   <= done_next;
      frame_err <= ferr_next;
      busy      <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    armed_next = armed;
    osc_next   = osc;
    nbits_next = nbits;
    shreg_next = shreg;
    data_next  = data_out;
    ferr_next  = frame_err;
    busy_next  = busy;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        // armed keeps a held-low line (break) from being re-read as a stream of starts
        if (rx_s) armed_next = 1'b1;
        if (armed && !rx_s) begin
          osc_next   = '0;
          nbits_next = '0;
          busy_next  = 1'b1;
          armed_next = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          if (osc == OSC_HALF) begin
            if (!rx_s) begin
              osc_next   = '0;
              state_next = DATA;
            end else begin
              busy_next  = 1'b0;
              state_next = IDLE;
            end
          end else begin
            osc_next = osc + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (osc == OSC_LAST) begin
            shreg_next = {rx_s, shreg[BYTE_WIDTH-1:1]};
            osc_next   = '0;
            if (nbits == NB_LAST) state_next = STOP;
            else                  nbits_next = nbits + 1'b1;
          end else begin
            osc_next = osc + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (osc == OSC_LAST) begin
            data_next  = shreg;
            ferr_next  = ~rx_s;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
          end else begin
            osc_next = osc + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are driven tick-aligned by a bench-side
// transmitter model; a negedge monitor logs every rx_done with its data and tick count.
module tb_uart_receiver;

  localparam int TDIV = 2;
  localparam int NLB  = 64;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       rx;
  logic       tick = 1'b0;
  logic [7:0] data_out;
  logic       rx_done, frame_err, busy;

  int checks = 0;
  int errors = 0;
  int div = 0;
  int tick_count = 0;
  int done_cnt = 0;
  int done_hi_prev = 0;
  int double_cnt = 0;
  logic [7:0] done_data[$];
  logic       done_err[$];
  int         done_tick[$];
  logic [7:0] lb_exp[$];

  uart_receiver #(.BYTE_WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .arst_n(arst_n), .rx(rx), .tick(tick),
    .data_out(data_out), .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div  = (div + 1) % TDIV;
    tick = (div == 0);
  end

  always @(posedge clk) if (tick) tick_count <= tick_count + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      done_data.push_back(data_out);
      done_err.push_back(frame_err);
      done_tick.push_back(tick_count);
      if (done_hi_prev != 0) double_cnt++;
    end
    done_hi_prev = rx_done ? 1 : 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    @(posedge clk);
    while (!tick) @(posedge clk);
    #1;
  endtask

  task automatic hold_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  // caller must be tick-aligned (just after a tick edge); returns aligned again
  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    t0 = tick_count;
    rx = 1'b0;
    hold_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold_ticks(16);
    end
    rx = stop;
    hold_ticks(16);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, n0;
    logic [7:0] b, d5a;

    arst_n = 1'b0;
    rx     = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_data", data_out, 8'h00);
    check("reset_done", rx_done, 1'b0);
    check("reset_ferr", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    arst_n = 1'b1;
    hold_ticks(10);

    // 1: good frame 0xA5, timing of rx_done against the mid-stop tick
    n0 = done_cnt;
    send_frame(8'hA5, 1'b1, t0);
    hold_ticks(20);
    check("t1_count", done_cnt - n0, 1);
    check("t1_data", done_data[n0], 8'hA5);
    check("t1_ferr", done_err[n0], 1'b0);
    check("t1_timing", done_tick[n0] - t0, 153);
    check("t1_busy", busy, 1'b0);

    // 2: 4-tick glitch aborts in START
    n0 = done_cnt;
    rx = 1'b0;
    hold_ticks(2);
    check("t2_busy_hi", busy, 1'b1);
    hold_ticks(2);
    rx = 1'b1;
    hold_ticks(20);
    check("t2_busy_lo", busy, 1'b0);
    check("t2_no_done", done_cnt - n0, 0);
    check("t2_data_kept", data_out, 8'hA5);

    // 3: stop bit 0, line held low for three frame times
    n0 = done_cnt;
    send_frame(8'h3C, 1'b0, t0);
    hold_ticks(480);
    check("t3_count", done_cnt - n0, 1);
    check("t3_data", data_out, 8'h3C);
    check("t3_ferr", frame_err, 1'b1);
    check("t3_busy", busy, 1'b0);
    rx = 1'b1;
    hold_ticks(16);
    send_frame(8'h96, 1'b1, t0);
    hold_ticks(20);
    check("t3_rearm_count", done_cnt - n0, 2);
    check("t3_rearm_data", data_out, 8'h96);
    check("t3_rearm_ferr", frame_err, 1'b0);

    // 4: back-to-back frames with no idle gap
    n0 = done_cnt;
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    hold_ticks(20);
    check("t4_count", done_cnt - n0, 2);
    check("t4_data0", done_data[n0], 8'h00);
    check("t4_data1", done_data[n0+1], 8'hFF);
    check("t4_ferr0", done_err[n0], 1'b0);
    check("t4_ferr1", done_err[n0+1], 1'b0);
    check("t4_spacing", done_tick[n0+1] - done_tick[n0], 160);

    // 5: reset pulse in the middle of data bit 4 of 0x5A, then a clean 0x81
    n0 = done_cnt;
    d5a = 8'h5A;
    rx = 1'b0;
    hold_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = d5a[i];
      hold_ticks(16);
    end
    rx = d5a[4];
    hold_ticks(8);
    check("t5_busy_pre", busy, 1'b1);
    arst_n = 1'b0;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t5_rst_data", data_out, 8'h00);
    check("t5_rst_done", rx_done, 1'b0);
    check("t5_rst_ferr", frame_err, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    hold_ticks(200);
    check("t5_no_done", done_cnt - n0, 0);
    check("t5_data_idle", data_out, 8'h00);
    send_frame(8'h81, 1'b1, t0);
    hold_ticks(20);
    check("t5_count", done_cnt - n0, 1);
    check("t5_data", data_out, 8'h81);
    check("t5_ferr", frame_err, 1'b0);

    // 6: loopback stream of random bytes from the transmitter model
    n0 = done_cnt;
    for (int i = 0; i < NLB; i++) begin
      b = 8'($urandom_range(0, 255));
      lb_exp.push_back(b);
      send_frame(b, 1'b1, t0);
    end
    hold_ticks(20);
    check("t6_count", done_cnt - n0, NLB);
    for (int i = 0; i < NLB; i++) begin
      check("t6_data", (n0 + i < done_data.size()) ? {24'h0, done_data[n0+i]} : 32'hDEAD,
            {24'h0, lb_exp[i]});
      check("t6_ferr", (n0 + i < done_err.size()) ? {31'h0, done_err[n0+i]} : 32'hDEAD, 0);
    end

    check("done_never_adjacent", double_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
